// File: rtl/video_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | video_pkg : shared video types, derived-size helpers and blank constants   |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
package video_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ERROR  = 2'd2
  } state_e;

  localparam logic [15:0] c_RGB565_BLANK = 16'h0000;

  function automatic int calc_ratio(input int fifo_dw, input int pix_w);
    return fifo_dw / pix_w;
  endfunction

  function automatic int calc_frame_words(input int h_active, input int v_active, input int ratio);
    return (h_active * v_active) / ratio;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_fifo_pixel_unpacker_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ddr_fifo_pixel_unpacker_if : first-word-fall-through FIFO read port        |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface ddr_fifo_pixel_unpacker_if #(
  parameter int FIFO_DW = 32
);

  logic [FIFO_DW-1:0] fifo_rd_data;
  logic               fifo_rd_vld;
  logic               fifo_rd_en;

  // master pops the FIFO; slave is the FIFO read side presenting its head word
  modport master (
    input  fifo_rd_data,
    input  fifo_rd_vld,
    output fifo_rd_en
  );

  modport slave (
    output fifo_rd_data,
    output fifo_rd_vld,
    input  fifo_rd_en
  );

endinterface
`default_nettype wire

// File: rtl/vs_edge_det.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vs_edge_det : registered rising-edge detector for video sync signals       |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module vs_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;

endmodule
`default_nettype wire

// File: rtl/ddr_fifo_pixel_unpacker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ddr_fifo_pixel_unpacker : splits FWFT FIFO words into one pixel per DE     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module ddr_fifo_pixel_unpacker
  import video_pkg::*;
#(
  parameter int              FIFO_DW     = 32,
  parameter int              PIX_W       = 16,
  parameter int              H_ACTIVE    = 1280,
  parameter int              V_ACTIVE    = 720,
  parameter logic [PIX_W-1:0] BLANK_PIXEL = PIX_W'(c_RGB565_BLANK)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        vs_in,
  input  logic                        de_in,
  ddr_fifo_pixel_unpacker_if.master   fifo,
  output logic [PIX_W-1:0]            pix_data,
  output logic                        pix_de,
  output logic                        pix_vs,
  output logic                        underflow,
  output logic                        frame_done,
  output logic [15:0]                 err_cnt
);

  localparam int RATIO       = calc_ratio(FIFO_DW, PIX_W);
  localparam int FRAME_WORDS = calc_frame_words(H_ACTIVE, V_ACTIVE, RATIO);
  localparam int IDX_W       = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int WCNT_W      = $clog2(FRAME_WORDS + 1);

  localparam logic [IDX_W-1:0]  c_LAST_IDX  = IDX_W'(RATIO - 1);
  localparam logic [WCNT_W-1:0] c_LAST_WORD = WCNT_W'(FRAME_WORDS - 1);

  state_e              state_q,      state_d;
  logic [IDX_W-1:0]    pix_idx_q,    pix_idx_d;
  logic [WCNT_W-1:0]   word_cnt_q,   word_cnt_d;
  logic                underflow_q,  underflow_d;
  logic [15:0]         err_cnt_q,    err_cnt_d;
  logic [PIX_W-1:0]    pix_data_q,   pix_data_d;
  logic                pix_de_q,     pix_de_d;
  logic                pix_vs_q,     pix_vs_d;
  logic                frame_done_q, frame_done_d;

  logic                w_vs_rise;
  logic                w_rd_en;
  logic                w_pop;
  logic [1:0]          w_err_inc;
  logic [16:0]         w_err_sum;
  logic [PIX_W-1:0]    w_pix;

  vs_edge_det u_vs_edge_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (vs_in),
    .rise_o (w_vs_rise)
  );

  assign w_pix = fifo.fifo_rd_data[int'(pix_idx_q) * PIX_W +: PIX_W];

  always_comb begin
    state_d      = state_q;
    pix_idx_d    = pix_idx_q;
    word_cnt_d   = word_cnt_q;
    underflow_d  = underflow_q;
    pix_data_d   = BLANK_PIXEL;
    pix_de_d     = de_in;
    pix_vs_d     = vs_in;
    frame_done_d = 1'b0;
    w_rd_en      = 1'b0;
    w_pop        = 1'b0;
    w_err_inc    = 2'd0;
    w_err_sum    = 17'd0;
    err_cnt_d    = err_cnt_q;

    unique case (state_q)
      ACTIVE: begin
        if (de_in) begin
          if (fifo.fifo_rd_vld) begin
            pix_data_d = w_pix;
            w_rd_en    = (pix_idx_q == c_LAST_IDX);
            pix_idx_d  = (pix_idx_q == c_LAST_IDX) ? '0 : pix_idx_q + 1'b1;
          end else begin
            underflow_d = 1'b1;
            w_err_inc   = 2'd1;
            state_d     = ERROR;
          end
        end
      end
      // drain the rest of the frame so the next frame starts word-aligned
      ERROR: begin
        w_rd_en = fifo.fifo_rd_vld;
      end
      default: begin
        w_rd_en = 1'b0;
      end
    endcase

    w_pop = w_rd_en & fifo.fifo_rd_vld;
    if (w_pop) begin
      word_cnt_d = word_cnt_q + 1'b1;
      if (word_cnt_q == c_LAST_WORD) begin
        frame_done_d = 1'b1;
        state_d      = IDLE;
      end
    end

    // a sync edge landing on the final pop is a clean frame boundary, not an abort
    if (w_vs_rise) begin
      if ((state_q != IDLE) && !frame_done_d) begin
        w_err_inc = w_err_inc + 2'd1;
      end
      state_d     = ACTIVE;
      pix_idx_d   = '0;
      word_cnt_d  = '0;
      underflow_d = 1'b0;
    end

    w_err_sum = {1'b0, err_cnt_q} + {15'd0, w_err_inc};
    err_cnt_d = w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pix_idx_q    <= '0;
      word_cnt_q   <= '0;
      underflow_q  <= 1'b0;
      err_cnt_q    <= 16'd0;
      pix_data_q   <= BLANK_PIXEL;
      pix_de_q     <= 1'b0;
      pix_vs_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_idx_q    <= pix_idx_d;
      word_cnt_q   <= word_cnt_d;
      underflow_q  <= underflow_d;
      err_cnt_q    <= err_cnt_d;
      pix_data_q   <= pix_data_d;
      pix_de_q     <= pix_de_d;
      pix_vs_q     <= pix_vs_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign fifo.fifo_rd_en = w_rd_en;
  assign pix_data        = pix_data_q;
  assign pix_de          = pix_de_q;
  assign pix_vs          = pix_vs_q;
  assign underflow       = underflow_q;
  assign frame_done      = frame_done_q;
  assign err_cnt         = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ddr_fifo_pixel_unpacker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ddr_fifo_pixel_unpacker : directed scoreboard bench, 4x2 frame, 2 px/wd |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_ddr_fifo_pixel_unpacker;
  import video_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vs_in;
  logic        de_in;
  logic [15:0] pix_data;
  logic        pix_de;
  logic        pix_vs;
  logic        underflow;
  logic        frame_done;
  logic [15:0] err_cnt;

  logic [31:0] fq[$];
  logic [15:0] exp_q[$];
  int          n_cmp  = 0;
  int          n_err  = 0;
  int          pops   = 0;
  int          fd_cnt = 0;
  int          p0;
  int          f0;

  always #5 clk = ~clk;

  ddr_fifo_pixel_unpacker_if #(.FIFO_DW(32)) bus ();

  ddr_fifo_pixel_unpacker #(
    .FIFO_DW     (32),
    .PIX_W       (16),
    .H_ACTIVE    (4),
    .V_ACTIVE    (2),
    .BLANK_PIXEL (16'h0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vs_in      (vs_in),
    .de_in      (de_in),
    .fifo       (bus),
    .pix_data   (pix_data),
    .pix_de     (pix_de),
    .pix_vs     (pix_vs),
    .underflow  (underflow),
    .frame_done (frame_done),
    .err_cnt    (err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // one clock: present FIFO head, drive sync/de, pop on handshake, score output
  task automatic step(input logic vs, input logic de, input logic [15:0] exp_pix);
    logic popped;
    vs_in            = vs;
    de_in            = de;
    bus.fifo_rd_vld  = (fq.size() != 0);
    bus.fifo_rd_data = (fq.size() != 0) ? fq[0] : 32'hDEAD_BEEF;
    if (de) exp_q.push_back(exp_pix);
    #1;
    popped = bus.fifo_rd_en && bus.fifo_rd_vld;
    if (bus.fifo_rd_en) check("rd_en_needs_vld", 32'(bus.fifo_rd_vld), 32'd1);
    @(posedge clk);
    #1;
    if (popped) begin
      void'(fq.pop_front());
      pops++;
    end
    if (frame_done) fd_cnt++;
    check("pix_de", 32'(pix_de), 32'(de));
    check("pix_vs", 32'(pix_vs), 32'(vs));
    if (pix_de) begin
      if (exp_q.size() == 0) check("pix_unexpected", 32'(pix_de), 32'd0);
      else                   check("pix_data", 32'(pix_data), 32'(exp_q.pop_front()));
    end
    @(negedge clk);
  endtask

  task automatic pixels(input int n, input logic [15:0] first);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, first + 16'(i));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n            = 1'b0;
    vs_in            = 1'b0;
    de_in            = 1'b0;
    bus.fifo_rd_vld  = 1'b1;
    bus.fifo_rd_data = 32'h1234_5678;
    repeat (2) @(negedge clk);
    check("rst_pix_data",   32'(pix_data),    32'd0);
    check("rst_pix_de",     32'(pix_de),      32'd0);
    check("rst_pix_vs",     32'(pix_vs),      32'd0);
    check("rst_rd_en",      32'(bus.fifo_rd_en), 32'd0);
    check("rst_underflow",  32'(underflow),   32'd0);
    check("rst_frame_done", 32'(frame_done),  32'd0);
    check("rst_err_cnt",    32'(err_cnt),     32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // normal frame
    fq.push_back(32'h0002_0001); fq.push_back(32'h0004_0003);
    fq.push_back(32'h0006_0005); fq.push_back(32'h0008_0007);
    step(1'b1, 1'b0, 16'h0);
    pixels(8, 16'h0001);
    check("t1_fd_pulse",  32'(frame_done), 32'd1);
    check("t1_fd_count",  32'(fd_cnt),     32'd1);
    check("t1_pops",      32'(pops),       32'd4);
    check("t1_underflow", 32'(underflow),  32'd0);
    check("t1_err_cnt",   32'(err_cnt),    32'd0);
    step(1'b0, 1'b0, 16'h0);
    check("t1_fd_one_cycle", 32'(frame_done), 32'd0);

    // underflow after two words, late words drained
    p0 = pops;
    f0 = fd_cnt;
    fq.push_back(32'h0012_0011); fq.push_back(32'h0014_0013);
    step(1'b1, 1'b0, 16'h0);
    pixels(4, 16'h0011);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'h0000);
    check("t2_underflow", 32'(underflow),     32'd1);
    check("t2_err_cnt",   32'(err_cnt),       32'd1);
    check("t2_state_err", 32'(dut.state_q),   32'(ERROR));
    fq.push_back(32'h0016_0015); fq.push_back(32'h0018_0017);
    step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 16'h0);
    check("t2_pops",       32'(pops),       32'(p0 + 4));
    check("t2_fd",         32'(fd_cnt),     32'(f0 + 1));
    check("t2_state_idle", 32'(dut.state_q), 32'(IDLE));
    check("t2_sticky",     32'(underflow),  32'd1);

    // early next-frame data waits in the FIFO
    p0 = pops;
    f0 = fd_cnt;
    fq.push_back(32'h0022_0021); fq.push_back(32'h0024_0023);
    fq.push_back(32'h0026_0025); fq.push_back(32'h0028_0027);
    step(1'b0, 1'b1, 16'h0000);
    step(1'b0, 1'b1, 16'h0000);
    check("t3_no_idle_pop", 32'(pops), 32'(p0));
    step(1'b1, 1'b0, 16'h0);
    check("t3_uf_cleared", 32'(underflow), 32'd0);
    pixels(8, 16'h0021);
    check("t3_pops", 32'(pops),   32'(p0 + 4));
    check("t3_fd",   32'(fd_cnt), 32'(f0 + 1));

    // abort after two pops; stale words remain and feed the restarted frame
    p0 = pops;
    f0 = fd_cnt;
    fq.push_back(32'h0032_0031); fq.push_back(32'h0034_0033);
    fq.push_back(32'h0036_0035); fq.push_back(32'h0038_0037);
    step(1'b1, 1'b0, 16'h0);
    pixels(4, 16'h0031);
    check("t4_pops_pre", 32'(pops), 32'(p0 + 2));
    step(1'b1, 1'b0, 16'h0);
    check("t4_err_cnt",  32'(err_cnt),        32'd2);
    check("t4_word_cnt", 32'(dut.word_cnt_q), 32'd0);
    check("t4_pix_idx",  32'(dut.pix_idx_q),  32'd0);
    check("t4_state",    32'(dut.state_q),    32'(ACTIVE));
    fq.push_back(32'h003A_0039); fq.push_back(32'h003C_003B);
    pixels(8, 16'h0035);
    check("t4_fd", 32'(fd_cnt), 32'(f0 + 1));

    // sync edge coinciding with the final pop
    fq.push_back(32'h0042_0041); fq.push_back(32'h0044_0043);
    fq.push_back(32'h0046_0045); fq.push_back(32'h0048_0047);
    step(1'b1, 1'b0, 16'h0);
    pixels(7, 16'h0041);
    step(1'b1, 1'b1, 16'h0048);
    check("t5_fd",       32'(frame_done),     32'd1);
    check("t5_err_cnt",  32'(err_cnt),        32'd2);
    check("t5_state",    32'(dut.state_q),    32'(ACTIVE));
    check("t5_word_cnt", 32'(dut.word_cnt_q), 32'd0);

    // saturated error counter, then asynchronous reset mid-frame
    force dut.err_cnt_q = 16'hFFFF;
    step(1'b0, 1'b0, 16'h0);
    release dut.err_cnt_q;
    step(1'b0, 1'b1, 16'h0000);
    check("t6_err_sat",   32'(err_cnt),      32'h0000_FFFF);
    check("t6_underflow", 32'(underflow),    32'd1);
    check("t6_state_err", 32'(dut.state_q),  32'(ERROR));
    step(1'b1, 1'b1, 16'h0000);
    check("t6_abort_sat", 32'(err_cnt),      32'h0000_FFFF);
    fq.push_back(32'h0052_0051);
    bus.fifo_rd_vld  = 1'b1;
    bus.fifo_rd_data = 32'h0052_0051;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_pix_data",   32'(pix_data),       32'd0);
    check("t6_rst_pix_de",     32'(pix_de),         32'd0);
    check("t6_rst_pix_vs",     32'(pix_vs),         32'd0);
    check("t6_rst_rd_en",      32'(bus.fifo_rd_en), 32'd0);
    check("t6_rst_underflow",  32'(underflow),      32'd0);
    check("t6_rst_frame_done", 32'(frame_done),     32'd0);
    check("t6_rst_err_cnt",    32'(err_cnt),        32'd0);
    check("t6_rst_state",      32'(dut.state_q),    32'(IDLE));
    fq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
